// File: rtl/accumulate_ctrl_16bit.sv
`default_nettype none
// ============================================================================
// Module      : accumulate_ctrl_16bit
// Description : Burst accumulation controller placed in front of a
//               combinational 16-bit adder. Accepts NUM_SAMPLES unsigned
//               samples over a valid/ready handshake, feeds the adder with
//               (running total, sample), captures sum/overflow, and presents
//               the final total (saturated or wrapped) with a one-cycle
//               result_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module accumulate_ctrl_16bit #(
    parameter int NUM_SAMPLES = 4,   // samples per burst, 1..255
    parameter int SAT_ENABLE  = 1    // 1: clamp on overflow, 0: wrap modulo 2^16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_ovf,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        sat_flag,
    output logic        busy
);

    // Sample counter is just wide enough to hold NUM_SAMPLES itself.
    localparam int              c_CW   = $clog2(NUM_SAMPLES + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NUM_SAMPLES - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);
    localparam logic            c_SAT  = (SAT_ENABLE != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic [15:0]       acc_q,    acc_d;
    logic [c_CW-1:0]   count_q,  count_d;
    logic              sat_q,    sat_d;
    logic [15:0]       result_q, result_d;
    logic              rvalid_q, rvalid_d;

    logic              w_accept;
    logic [15:0]       w_acc_next;

    // The adder sees the live accumulator and the incoming sample; carry-in is never used.
    assign add_a   = acc_q;
    assign add_b   = in_data;
    assign add_cin = 1'b0;

    // Ready/busy are pure functions of the state so they drop the cycle after the last accept.
    assign in_ready = (state_q == S_ACCUM);
    assign busy     = (state_q != S_IDLE);
    assign w_accept = in_valid & in_ready;

    // On overflow the total either clamps to all-ones or keeps the adder's low 16 bits.
    assign w_acc_next = (add_ovf && c_SAT) ? 16'hFFFF : add_sum;

    assign result       = result_q;
    assign result_valid = rvalid_q;
    assign sat_flag     = sat_q;

    // Next-state logic: everything holds by default, result_valid is a single-cycle pulse.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        sat_d    = sat_q;
        result_d = result_q;
        rvalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // in_valid is ignored here; only start moves the controller.
                if (start) begin
                    state_d = S_ACCUM;
                    acc_d   = 16'h0000;
                    count_d = '0;
                    sat_d   = 1'b0;
                end
            end
            S_ACCUM: begin
                // No timeout: without in_valid all state simply holds.
                if (w_accept) begin
                    acc_d   = w_acc_next;
                    sat_d   = sat_q | add_ovf;
                    count_d = count_q + c_ONE;
                    if (count_q == c_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // start is not looked at here; the earliest restart is the next IDLE cycle.
                result_d = acc_q;
                rvalid_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any burst and clears the published result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= 16'h0000;
            count_q  <= '0;
            sat_q    <= 1'b0;
            result_q <= 16'h0000;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accumulate_ctrl_16bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_accumulate_ctrl_16bit
// Description : Self-checking bench for accumulate_ctrl_16bit. Two instances
//               (saturating and wrapping) share one stimulus stream; each has
//               its own behavioural 16-bit adder. Expected totals come from a
//               vector table and from an integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accumulate_ctrl_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;

    logic        s_ready, s_cin, s_rv, s_flag, s_busy, s_ovf;
    logic [15:0] s_a, s_b, s_sum, s_res;
    logic        w_ready, w_cin, w_rv, w_flag, w_busy, w_ovf;
    logic [15:0] w_a, w_b, w_sum, w_res;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Behavioural adders standing in for adder_16bit.
    assign {s_ovf, s_sum} = {1'b0, s_a} + {1'b0, s_b} + {16'h0000, s_cin};
    assign {w_ovf, w_sum} = {1'b0, w_a} + {1'b0, w_b} + {16'h0000, w_cin};

    accumulate_ctrl_16bit #(.NUM_SAMPLES(4), .SAT_ENABLE(1)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_ready), .add_a(s_a), .add_b(s_b), .add_cin(s_cin),
        .add_sum(s_sum), .add_ovf(s_ovf), .result(s_res), .result_valid(s_rv),
        .sat_flag(s_flag), .busy(s_busy)
    );

    accumulate_ctrl_16bit #(.NUM_SAMPLES(4), .SAT_ENABLE(0)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(w_ready), .add_a(w_a), .add_b(w_b), .add_cin(w_cin),
        .add_sum(w_sum), .add_ovf(w_ovf), .result(w_res), .result_valid(w_rv),
        .sat_flag(w_flag), .busy(w_busy)
    );

    typedef struct packed {
        logic [3:0][15:0] s;       // samples, s[0] first
        logic [3:0][7:0]  gap;     // idle cycles before each sample
        logic [15:0]      res_sat;
        logic             flg_sat;
        logic [15:0]      res_wrap;
        logic             flg_wrap;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: sum the first n samples with plain integers; on exceeding
    // 16 bits record the event and clamp or drop 2^16.
    function automatic logic [16:0] model(input logic [3:0][15:0] s, input int n, input bit sat);
        int  t;
        bit  f;
        t = 0;
        f = 1'b0;
        for (int i = 0; i < n; i++) begin
            t = t + int'(s[i]);
            if (t > 65535) begin
                f = 1'b1;
                t = sat ? 65535 : t - 65536;
            end
        end
        return {f, t[15:0]};
    endfunction

    // One complete burst with per-sample gaps and full end-of-burst checks.
    task automatic run_burst(input string tag, input vec_t v);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < int'(v.gap[i]); g++) begin
                check({tag, " ready_stall"}, {30'd0, s_ready, w_ready}, 32'd3);
                tick();
            end
            in_valid = 1'b1;
            in_data  = v.s[i];
            #1;
            check({tag, " add_a_sat"},  {16'd0, s_a}, {16'd0, model(v.s, i, 1'b1) & 17'h0FFFF});
            check({tag, " add_a_wrap"}, {16'd0, w_a}, {16'd0, model(v.s, i, 1'b0) & 17'h0FFFF});
            check({tag, " add_b/cin"}, {15'd0, s_cin, s_b}, {16'd0, v.s[i]});
            tick();
            in_valid = 1'b0;
        end
        check({tag, " done_ready_busy"}, {28'd0, s_ready, w_ready, s_busy, s_rv}, 32'h2);
        tick();
        check({tag, " rv"},       {30'd0, s_rv, w_rv}, 32'd3);
        check({tag, " res_sat"},  {15'd0, s_flag, s_res}, {15'd0, v.flg_sat, v.res_sat});
        check({tag, " res_wrap"}, {15'd0, w_flag, w_res}, {15'd0, v.flg_wrap, v.res_wrap});
        tick();
        check({tag, " rv_pulse/hold"}, {14'd0, s_rv, w_rv, s_res}, {16'd0, v.res_sat});
    endtask

    vec_t vecs[5];
    vec_t rv;
    int   pulses;

    initial begin
        vecs[0] = '{s: {16'd4, 16'd3, 16'd2, 16'd1}, gap: {8'd0, 8'd0, 8'd0, 8'd0},
                    res_sat: 16'd10, flg_sat: 1'b0, res_wrap: 16'd10, flg_wrap: 1'b0};
        vecs[1] = '{s: {16'd4, 16'd3, 16'd2, 16'd1}, gap: {8'd1, 8'd3, 8'd0, 8'd0},
                    res_sat: 16'd10, flg_sat: 1'b0, res_wrap: 16'd10, flg_wrap: 1'b0};
        vecs[2] = '{s: {16'h0000, 16'h0001, 16'h0020, 16'hFFF0}, gap: '0,
                    res_sat: 16'hFFFF, flg_sat: 1'b1, res_wrap: 16'h0011, flg_wrap: 1'b1};
        vecs[3] = '{s: {16'h0000, 16'h0000, 16'h0002, 16'hFFFF}, gap: '0,
                    res_sat: 16'hFFFF, flg_sat: 1'b1, res_wrap: 16'h0001, flg_wrap: 1'b1};
        vecs[4] = '{s: {16'h0005, 16'h0000, 16'h8000, 16'h8000}, gap: {8'd0, 8'd2, 8'd0, 8'd0},
                    res_sat: 16'hFFFF, flg_sat: 1'b1, res_wrap: 16'h0005, flg_wrap: 1'b1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        #1;
        check("reset_state", {12'd0, s_ready, s_rv, s_flag, s_busy, s_res},
              32'd0);
        tick(); tick();
        rst = 1'b0;

        // Table-driven bursts (basic, stalled, saturation, wrap, exact 2^16).
        foreach (vecs[k]) run_burst($sformatf("vec%0d", k), vecs[k]);

        // A sum that reaches exactly 16'hFFFF must not flag.
        rv = '{s: {16'h0000, 16'h0000, 16'h7FFF, 16'h8000}, gap: '0,
               res_sat: 16'hFFFF, flg_sat: 1'b0, res_wrap: 16'hFFFF, flg_wrap: 1'b0};
        run_burst("edge_ffff", rv);

        // Randomised bursts against the reference model.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) begin
                rv.s[i]   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hC000, 16'hFFFF))
                                                        : 16'($urandom);
                rv.gap[i] = 8'($urandom_range(0, 2));
            end
            {rv.flg_sat,  rv.res_sat}  = model(rv.s, 4, 1'b1);
            {rv.flg_wrap, rv.res_wrap} = model(rv.s, 4, 1'b0);
            run_burst($sformatf("rand%0d", r), rv);
        end

        // Reset in the middle of a burst: immediate clear, no late pulse.
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 16'h0100; tick(); tick(); in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midburst_reset", {12'd0, s_ready, s_rv, s_flag, s_busy, s_res}, 32'd0);
        check("midburst_reset_a", {16'd0, s_a}, 32'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (s_rv || w_rv || s_busy) pulses++;
        end
        check("no_pulse_after_reset", pulses, 0);

        // in_valid in IDLE is never accepted.
        in_valid = 1'b1; in_data = 16'h1234;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("idle_ready", {30'd0, s_ready, s_busy}, 32'd0);
        end
        in_valid = 1'b0;

        // start held high through a burst: no restart until the first IDLE cycle.
        start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'd7; tick();
        end
        in_valid = 1'b0;
        check("held_start_done", {30'd0, s_busy, s_ready}, 32'h2);
        tick();
        check("held_start_result", {15'd0, s_rv, s_res}, {15'd0, 1'b1, 16'd28});
        tick();
        check("held_start_restart", {29'd0, s_busy, s_ready, s_rv}, 32'h6);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'd3; tick();
        end
        in_valid = 1'b0;
        tick();
        check("restart_result", {15'd0, s_rv, s_res}, {15'd0, 1'b1, 16'd12});
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
